// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS frequency-sweep controller.
`ifndef ADDR_WIDTH
`include "define.sv"
`endif

package dds_pkg;

   localparam int FW_W_DEFAULT = 3;
   localparam int ADDR_W       = `ADDR_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DWELL,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      MODE_SINGLE   = 2'd0,
      MODE_REPEAT   = 2'd1,
      MODE_PINGPONG = 2'd2
   } mode_e;

   // The unused encoding 3 behaves as a single sweep.
   function automatic mode_e decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_REPEAT;
         2'd2:    return MODE_PINGPONG;
         default: return MODE_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/dds_dwell_cnt.sv
// Dwell down-counter: loads a hold count, counts down to zero and flags zero.
module dds_dwell_cnt #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   logic [DWELL_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec && !zero)
         count <= count - DWELL_W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/define.sv
// Build-wide macros shared by the DDS datapath and its controllers.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller driving a DDS frequency word, plus a phase-word
// register that can be reloaded at any time.
module dds_sweep_ctrl
   import dds_pkg::*;
#(
   parameter int DWELL_W = 16,
   parameter int FW_W    = FW_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [FW_W-1:0]    f_start,
   input  logic [FW_W-1:0]    f_stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               p_load,
   input  logic [ADDR_W-1:0]  p_offset,
   output logic [FW_W-1:0]    fword,
   output logic [ADDR_W-1:0]  pword,
   output logic               busy,
   output logic               done,
   output logic               step_tick,
   output logic               wrap_tick
);

   state_e             state, state_n;
   logic [FW_W-1:0]    fword_n;
   logic [FW_W-1:0]    sh_first, sh_first_n;
   logic [FW_W-1:0]    sh_last, sh_last_n;
   logic [DWELL_W-1:0] sh_dwell;
   mode_e              sh_mode;
   logic               dir_up, dir_up_n;
   logic               capture;
   logic               cnt_load, cnt_dec, cnt_zero;
   logic [DWELL_W-1:0] cnt_val;
   logic               step_n, wrap_n;

   dds_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_n    = state;
      fword_n    = fword;
      sh_first_n = sh_first;
      sh_last_n  = sh_last;
      dir_up_n   = dir_up;
      capture    = 1'b0;
      cnt_load   = 1'b0;
      cnt_val    = sh_dwell;
      cnt_dec    = 1'b0;
      step_n     = 1'b0;
      wrap_n     = 1'b0;

      if (stop) begin
         state_n = ST_IDLE;   // abort wins: everything else holds, no done pulse
      end else begin
         unique case (state)
            ST_IDLE: if (start) state_n = ST_LOAD;
            ST_LOAD: begin
               capture    = 1'b1;
               fword_n    = f_start;
               sh_first_n = f_start;
               sh_last_n  = f_stop;
               dir_up_n   = (f_stop >= f_start);
               cnt_load   = 1'b1;
               cnt_val    = dwell;
               state_n    = ST_DWELL;
            end
            ST_DWELL: begin
               if (!cnt_zero) begin
                  cnt_dec = 1'b1;
               end else if (fword != sh_last) begin
                  fword_n  = dir_up ? fword + FW_W'(1) : fword - FW_W'(1);
                  cnt_load = 1'b1;
                  step_n   = 1'b1;
               end else begin
                  case (sh_mode)
                     MODE_REPEAT: begin
                        fword_n  = sh_first;
                        cnt_load = 1'b1;
                        wrap_n   = 1'b1;
                     end
                     MODE_PINGPONG: begin
                        // Turn around at the endpoint without re-emitting it.
                        sh_first_n = sh_last;
                        sh_last_n  = sh_first;
                        dir_up_n   = !dir_up;
                        if (sh_first != sh_last)
                           fword_n = dir_up ? fword - FW_W'(1) : fword + FW_W'(1);
                        cnt_load = 1'b1;
                        wrap_n   = 1'b1;
                     end
                     default: state_n = ST_DONE;
                  endcase
               end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state     <= ST_IDLE;
         fword     <= '0;
         sh_first  <= '0;
         sh_last   <= '0;
         sh_dwell  <= '0;
         sh_mode   <= MODE_SINGLE;
         dir_up    <= 1'b1;
         step_tick <= 1'b0;
         wrap_tick <= 1'b0;
      end else begin
         state     <= state_n;
         fword     <= fword_n;
         sh_first  <= sh_first_n;
         sh_last   <= sh_last_n;
         dir_up    <= dir_up_n;
         step_tick <= step_n;
         wrap_tick <= wrap_n;
         if (capture) begin
            sh_dwell <= dwell;
            sh_mode  <= decode_mode(mode);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pword <= '0;
      else if (p_load)
         pword <= p_offset;
   end

   assign busy = (state == ST_LOAD) || (state == ST_DWELL);
   assign done = (state == ST_DONE);

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 16, giving the dwell counter width.
REQ-002 The block SHALL have parameter FW_W, default 3, giving the frequency-word width, matching the DDS Fword.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: sweep request pulse.
REQ-006 The block SHALL have port stop, input, 1 bit: abort request pulse.
REQ-007 The block SHALL have port mode, input, 2 bits: 0 SINGLE, 1 REPEAT, 2 PINGPONG; 3 is treated as SINGLE.
REQ-008 The block SHALL have ports f_start and f_stop, input, FW_W bits each: the sweep endpoints.
REQ-009 The block SHALL have port dwell, input, DWELL_W bits: hold count per frequency step.
REQ-010 The block SHALL have port p_load, input, 1 bit, and port p_offset, input, `ADDR_WIDTH bits: phase-word update.
REQ-011 The block SHALL have port fword, output, FW_W bits: drives the DDS Fword.
REQ-012 The block SHALL have port pword, output, `ADDR_WIDTH bits: drives the DDS Pword.
REQ-013 The block SHALL have ports busy, done, step_tick and wrap_tick, output, 1 bit each: status flags.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, DWELL and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to LOAD on the next edge; start outside IDLE SHALL be ignored.
REQ-016 LOAD SHALL capture the following and then go to DWELL:
- f_start, f_stop, dwell and mode into shadow registers;
- fword <= f_start;
- dir <= up if f_stop >= f_start, else down;
- counter <= dwell.
REQ-017 In DWELL, while counter != 0, the counter SHALL decrement each cycle, so each frequency is held dwell+1 cycles (dwell=0 gives 1 cycle).
REQ-018 In DWELL at counter==0 with fword != end, fword SHALL step +/-1 per dir, the counter SHALL reload the shadow dwell, and step_tick SHALL pulse for 1 cycle.
REQ-019 In DWELL at counter==0 with fword == end, the next action SHALL depend on the shadow mode:
- SINGLE: go to DONE;
- REPEAT: fword <= start, counter reload, wrap_tick pulse;
- PINGPONG: swap start/end shadows, invert dir, step fword one toward the new end (no step if start==end), counter reload, wrap_tick pulse.
REQ-020 DONE SHALL assert done for exactly 1 cycle, then return to IDLE; fword SHALL hold f_stop.
REQ-021 stop=1 in LOAD, DWELL or DONE SHALL force IDLE on the next edge, with fword holding its current value and no done pulse.
REQ-022 stop SHALL win over every other FSM event in the same cycle.
REQ-023 busy SHALL be 1 in LOAD and DWELL and 0 in IDLE and DONE.
REQ-024 p_load=1 SHALL load pword <= p_offset on the next edge in any state, independent of the FSM.
REQ-025 Endpoint arithmetic SHALL be unsigned; fword SHALL never leave the range [min(f_start,f_stop), max(f_start,f_stop)], and no wrap-around past 0 or 2^FW_W-1 SHALL occur.
REQ-026 f_start == f_stop SHALL be legal: the block holds that frequency dwell+1 cycles, then applies the mode action.
REQ-027 Input changes during a sweep SHALL have no effect until the next LOAD.

Reset
REQ-028 rst_n low SHALL asynchronously force:
- FSM to IDLE;
- fword, pword and counter to 0;
- busy, done, step_tick and wrap_tick to 0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL wait for a new start.

Structure
REQ-030 A shared package dds_pkg SHALL hold the state enum, the mode enum and the FW_W default; `ADDR_WIDTH SHALL come from define.sv.
REQ-031 The dwell down-counter (load, decrement, zero flag) SHALL be one sub-module named dds_dwell_cnt.

Verification
REQ-032 A SINGLE up-sweep SHALL be checked: f_start=1, f_stop=4, dwell=2 -> fword 1,2,3,4 held 3 cycles each, 3 step_ticks, done 1 cycle after the 4 hold, busy falls with done.
REQ-033 A REPEAT down-sweep SHALL be checked: f_start=5, f_stop=3, dwell=0 -> fword 5,4,3,5,4,3..., wrap_tick on each return to 5.
REQ-034 A PINGPONG sweep SHALL be checked: f_start=0, f_stop=7, dwell=1 -> fword 0..7..0, each value held 2 cycles, endpoints not repeated, wrap_tick at 7 and 0.
REQ-035 An abort SHALL be checked: stop at fword=3 mid-DWELL -> IDLE next cycle, fword stays 3, done stays 0; a start in the same cycle as stop is ignored.
REQ-036 Phase load and reset SHALL be checked:
- p_load with p_offset=12'h2A0 during a sweep -> pword=12'h2A0 next cycle, fword sequence undisturbed;
- rst_n pulse mid-sweep -> all outputs 0 immediately.
